vote_result_reporter: RTL

//  Read-out end of the voting machine. Watches i_voting_over and, on its rising edge, snapshots
//  the per-candidate counters and resolves the winner or tie. It then streams a result frame over
//  a byte-wide valid/ready link to the display/UART side. Sits directly downstream of voting_machine.

---
 rtl/vote_pkg.sv | 25 ++
 rtl/vote_result_reporter_if.sv | 9 +
 rtl/vote_winner_cmp.sv | 26 ++
 rtl/vote_result_reporter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// Shared types and constants for the vote result reporter.
// VOTE_REPORT_CHECKSUM_EN selects the 6-byte frame that ends in an XOR checksum byte.
package vote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_COMPARE,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [7:0] VOTE_HEADER = 8'hA5;

`ifdef VOTE_REPORT_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  localparam int IDX_W = $clog2(FRAME_LEN);
  typedef logic [IDX_W-1:0] byte_idx_t;
  localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

endpackage

// File: rtl/vote_result_reporter_if.sv
// Byte-wide valid/ready link from the reporter to the display/UART side.
interface vote_result_reporter_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/vote_winner_cmp.sv
// Combinational 3-way max resolver: unique max gives its index, shared non-zero max flags a tie.
module vote_winner_cmp
  import vote_pkg::*;
(
  input  logic [7:0] count1,
  input  logic [7:0] count2,
  input  logic [7:0] count3,
  output logic [1:0] winner,
  output logic       tie
);

  always_comb begin
    winner = 2'd0;
    tie    = 1'b0;
    if (count1 > count2 && count1 > count3)
      winner = 2'd1;
    else if (count2 > count1 && count2 > count3)
      winner = 2'd2;
    else if (count3 > count1 && count3 > count2)
      winner = 2'd3;
    else if ((|count1) || (|count2) || (|count3))
      // no unique max but something is non-zero, so the max is shared
      tie = 1'b1;
  end

endmodule

// File: rtl/vote_result_reporter.sv
// Snapshots the candidate counts on a rising i_voting_over, resolves winner/tie and streams a
// result frame. VOTE_REPORT_CHECKSUM_EN appends an XOR checksum byte to the frame.
//
// state   | meaning
// IDLE    | waiting for a rising edge of i_voting_over
// CAPTURE | counts latched, busy asserted
// COMPARE | winner/tie registered, header loaded
// SEND    | streaming frame bytes on the valid/ready link
// DONE    | frame complete, waiting for i_voting_over to drop
module vote_result_reporter
  import vote_pkg::*;
#(
  parameter int         CNT_W  = 6,
  parameter logic [7:0] HEADER = VOTE_HEADER
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_voting_over,
  input  logic [CNT_W-1:0]       i_count1,
  input  logic [CNT_W-1:0]       i_count2,
  input  logic [CNT_W-1:0]       i_count3,
  vote_result_reporter_if.master tx,
  output logic [1:0]             o_winner,
  output logic                   o_tie,
  output logic                   o_busy,
  output logic                   o_done
);

  state_t     state, state_n;
  logic       vo_q;
  logic [7:0] cap1, cap2, cap3, cap1_n, cap2_n, cap3_n;
  byte_idx_t  idx, idx_n, nxt_idx;
  logic [7:0] data_q, data_n, frame_byte, result_byte;
  logic       valid_q, valid_n;
  logic [1:0] winner_n, cmp_winner;
  logic       tie_n, cmp_tie, busy_n, done_n;
  logic       trigger;

  assign trigger     = i_voting_over & ~vo_q;
  assign result_byte = {5'b0, o_tie, o_winner};

  vote_winner_cmp u_cmp (
    .count1 (cap1),
    .count2 (cap2),
    .count3 (cap3),
    .winner (cmp_winner),
    .tie    (cmp_tie)
  );

  // o_winner/o_tie are registered in COMPARE, so they are stable before the result byte is needed
  always_comb begin
    nxt_idx = idx + 1'b1;
    case (nxt_idx)
      byte_idx_t'(1): frame_byte = cap1;
      byte_idx_t'(2): frame_byte = cap2;
      byte_idx_t'(3): frame_byte = cap3;
      byte_idx_t'(4): frame_byte = result_byte;
`ifdef VOTE_REPORT_CHECKSUM_EN
      byte_idx_t'(5): frame_byte = HEADER ^ cap1 ^ cap2 ^ cap3 ^ result_byte;
`endif
      default:        frame_byte = HEADER;
    endcase
  end

  always_comb begin
    state_n  = state;
    cap1_n   = cap1;
    cap2_n   = cap2;
    cap3_n   = cap3;
    idx_n    = idx;
    data_n   = data_q;
    valid_n  = valid_q;
    winner_n = o_winner;
    tie_n    = o_tie;
    busy_n   = o_busy;
    done_n   = o_done;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_n = ST_CAPTURE;
          cap1_n  = 8'(i_count1);
          cap2_n  = 8'(i_count2);
          cap3_n  = 8'(i_count3);
          busy_n  = 1'b1;
        end
      end
      ST_CAPTURE: state_n = ST_COMPARE;
      ST_COMPARE: begin
        state_n  = ST_SEND;
        winner_n = cmp_winner;
        tie_n    = cmp_tie;
        idx_n    = '0;
        data_n   = HEADER;
        valid_n  = 1'b1;
      end
      ST_SEND: begin
        if (valid_q && tx.ready) begin
          if (idx == LAST_IDX) begin
            state_n = ST_DONE;
            valid_n = 1'b0;
            data_n  = 8'h00;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n  = nxt_idx;
            data_n = frame_byte;
          end
        end
      end
      ST_DONE: begin
        if (!i_voting_over) begin
          state_n = ST_IDLE;
          done_n  = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      vo_q     <= 1'b0;
      cap1     <= 8'h00;
      cap2     <= 8'h00;
      cap3     <= 8'h00;
      idx      <= '0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      o_winner <= 2'd0;
      o_tie    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_n;
      vo_q     <= i_voting_over;
      cap1     <= cap1_n;
      cap2     <= cap2_n;
      cap3     <= cap3_n;
      idx      <= idx_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      o_winner <= winner_n;
      o_tie    <= tie_n;
      o_busy   <= busy_n;
      o_done   <= done_n;
    end
  end

  assign tx.data  = data_q;
  assign tx.valid = valid_q;

endmodule
